// File: rtl/agg_pair_deser_pkg.sv
// Shared definitions for the aggregated-selector receive path: default
// word geometry, FSM state encoding and the 2-bit selector decode.
package agg_pair_deser_pkg;

  localparam int DEF_PAIRS = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic logic pair_map(input logic [1:0] sel);
    logic y;
    case (sel)
      2'b00:   y = 1'b0;
      2'b01:   y = 1'b1;
      2'b10:   y = 1'b0;
      default: y = 1'b1;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/agg_pair_deser_fifo2.sv
// Two-entry FIFO with a registered head; entry 0 is always the head so the
// output never passes through a read mux.
module agg_fifo2 #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop_ok;
  logic         push_ok;

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    cnt_d   = cnt_q;
    pop_ok  = pop && (cnt_q != 2'd0);
    push_ok = push && ((cnt_q != 2'd2) || pop_ok);
    case ({push_ok, pop_ok})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = din;
        else               e1_d = din;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        e1_d  = '0;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          e0_d = din;
        end else begin
          e0_d = e1_q;
          e1_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = e0_q;
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/agg_pair_deser.sv
// Serial-to-parallel receiver: assembles framed MSB-first words of PAIRS
// 2-bit selectors, decodes each pair and queues the result for the consumer.
module agg_pair_deser
  import agg_pair_deser_pkg::*;
#(
  parameter int PAIRS = DEF_PAIRS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sin_valid,
  input  logic                 sin_bit,
  input  logic                 sin_start,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*PAIRS-1:0]   out_word,
  output logic [PAIRS-1:0]     out_y,
  output logic                 sync_err,
  output logic                 overflow,
  input  logic                 err_clr
);

  localparam int WORD_W = 2 * PAIRS;
  localparam int CNT_W  = $clog2(WORD_W);
  localparam int ENT_W  = WORD_W + PAIRS;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   sh_q, sh_d;
  logic                sync_err_q, sync_err_d;
  logic                overflow_q, overflow_d;

  logic [WORD_W-1:0]   word_in;
  logic [PAIRS-1:0]    y_in;
  logic                push;
  logic                pop;
  logic                drop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENT_W-1:0]    fifo_head;

  // Bits enter at the LSB; after WORD_W shifts the first bit sits in the MSB.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    sync_err_d = 1'b0;
    push       = 1'b0;
    word_in    = {sh_q[WORD_W-2:0], sin_bit};
    for (int i = 0; i < PAIRS; i++) begin
      y_in[i] = pair_map(word_in[2*i +: 2]);
    end
    if (sin_valid) begin
      if (sin_start) begin
        sync_err_d = (state_q == SHIFT);
        sh_d       = {{(WORD_W-1){1'b0}}, sin_bit};
        cnt_d      = CNT_W'(1);
        state_d    = SHIFT;
      end else if (state_q == SHIFT) begin
        sh_d = word_in;
        if (cnt_q == CNT_W'(WORD_W - 1)) begin
          push    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign pop  = !fifo_empty && out_ready;
  assign drop = push && fifo_full && !pop;

  always_comb begin
    overflow_d = overflow_q;
    if (err_clr) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      sync_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      sync_err_q <= sync_err_d;
      overflow_q <= overflow_d;
    end
  end

  agg_fifo2 #(
    .W (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({word_in, y_in}),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_word  = fifo_head[ENT_W-1:PAIRS];
  assign out_y     = fifo_head[PAIRS-1:0];
  assign sync_err  = sync_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_agg_pair_deser.sv
// Bench for agg_pair_deser: fixed vector table, directed multi-cycle
// sequences and randomized traffic against a queue-based reference model.
module tb_agg_pair_deser;

  localparam int PAIRS  = 4;
  localparam int WORD_W = 2 * PAIRS;

  logic              clk;
  logic              rst_n;
  logic              sin_valid;
  logic              sin_bit;
  logic              sin_start;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_word;
  logic [PAIRS-1:0]  out_y;
  logic              sync_err;
  logic              overflow;
  logic              err_clr;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [WORD_W-1:0] mq[$];
  bit                bits[$];
  bit                inword;
  bit                m_ovf;
  bit                m_sync;

  typedef struct {
    bit               v, b, s, r, c;
    bit               ev;
    logic [WORD_W-1:0] ew;
    logic [PAIRS-1:0]  ey;
    bit               es;
    bit               eo;
  } vec_t;

  vec_t tbl[$];

  agg_pair_deser #(
    .PAIRS (PAIRS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin_valid (sin_valid),
    .sin_bit   (sin_bit),
    .sin_start (sin_start),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_y     (out_y),
    .sync_err  (sync_err),
    .overflow  (overflow),
    .err_clr   (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [PAIRS-1:0] ymap(input logic [WORD_W-1:0] w);
    logic [PAIRS-1:0] y;
    for (int i = 0; i < PAIRS; i++) begin
      case (w[2*i +: 2])
        2'b00, 2'b10: y[i] = 1'b0;
        default:      y[i] = 1'b1;
      endcase
    end
    return y;
  endfunction

  function automatic vec_t mk(input bit v, input bit b, input bit s, input bit ev,
                              input logic [WORD_W-1:0] ew, input logic [PAIRS-1:0] ey,
                              input bit es);
    vec_t t;
    t.v = v; t.b = b; t.s = s; t.r = 1'b1; t.c = 1'b0;
    t.ev = ev; t.ew = ew; t.ey = ey; t.es = es; t.eo = 1'b0;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    bits.delete();
    inword = 1'b0;
    m_ovf  = 1'b0;
    m_sync = 1'b0;
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_word", 32'(out_word), 32'(mq[0]));
      chk("out_y", 32'(out_y), 32'(ymap(mq[0])));
    end
    chk("sync_err", 32'(sync_err), 32'(m_sync));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // drive one cycle, advance the model across the edge, then compare
  task automatic cyc(input bit v, input bit b, input bit s, input bit r, input bit c);
    bit                pop_ok;
    bit                do_push;
    logic [WORD_W-1:0] w;
    sin_valid = v;
    sin_bit   = b;
    sin_start = s;
    out_ready = r;
    err_clr   = c;
    @(posedge clk);
    pop_ok  = (mq.size() > 0) && r;
    do_push = 1'b0;
    m_sync  = 1'b0;
    w       = '0;
    if (v) begin
      if (s) begin
        m_sync = inword;
        bits.delete();
        bits.push_back(b);
        inword = 1'b1;
      end else if (inword) begin
        bits.push_back(b);
      end
      if (inword && bits.size() == WORD_W) begin
        for (int k = 0; k < WORD_W; k++) w = {w[WORD_W-2:0], bits[k]};
        do_push = 1'b1;
        bits.delete();
        inword = 1'b0;
      end
    end
    if (pop_ok) void'(mq.pop_front());
    if (c) m_ovf = 1'b0;
    if (do_push) begin
      if (mq.size() < 2) mq.push_back(w);
      else               m_ovf = 1'b1;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w, input bit r_body, input bit r_last);
    for (int i = WORD_W - 1; i >= 0; i--) begin
      cyc(1'b1, w[i], i == WORD_W - 1, (i == 0) ? r_last : r_body, 1'b0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    sin_valid = 1'b0;
    sin_bit   = 1'b0;
    sin_start = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_word", 32'(out_word), 32'd0);
    chk("rst_y", 32'(out_y), 32'd0);
    chk("rst_sync", 32'(sync_err), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    // basic word 0x6C, then resync into 0xF1
    tbl.push_back(mk(1, 0, 1, 0, 8'h00, 4'h0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 8'h00, 4'h0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 8'h00, 4'h0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 4'h0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 8'h00, 4'h0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 8'h00, 4'h0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 4'h0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 8'h6C, 4'hA, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 4'h0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 8'h00, 4'h0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 4'h0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 8'h00, 4'h0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 4'h0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 8'h00, 4'h0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 8'h00, 4'h0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 8'h00, 4'h0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 8'h00, 4'h0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 4'h0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 4'h0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 4'h0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 8'hF1, 4'hD, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 4'h0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].v, tbl[i].b, tbl[i].s, tbl[i].r, tbl[i].c);
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk("tbl_word", 32'(out_word), 32'(tbl[i].ew));
        chk("tbl_y", 32'(out_y), 32'(tbl[i].ey));
      end
      chk("tbl_sync", 32'(sync_err), 32'(tbl[i].es));
      chk("tbl_ovf", 32'(overflow), 32'(tbl[i].eo));
    end

    // gaps of 3 idle cycles between bits 3 and 4
    begin
      logic [WORD_W-1:0] w;
      w = 8'h6C;
      for (int i = 0; i < WORD_W; i++) begin
        if (i == 4) repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, w[WORD_W-1-i], i == 0, 1'b1, 1'b0);
        if (i == WORD_W - 2) chk("gap_not_early", 32'(out_valid), 32'd0);
      end
      chk("gap_valid", 32'(out_valid), 32'd1);
      chk("gap_word", 32'(out_word), 32'h6C);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // backpressure and overflow
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    chk("bp_ovf_pre", 32'(overflow), 32'd0);
    send_word(8'h33, 1'b0, 1'b0);
    chk("bp_ovf", 32'(overflow), 32'd1);
    chk("bp_head", 32'(out_word), 32'h11);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_pop1", 32'(out_word), 32'h22);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_empty", 32'(out_valid), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_clr", 32'(overflow), 32'd0);

    // full buffer, third word completes on a pop edge
    send_word(8'h44, 1'b0, 1'b0);
    send_word(8'h55, 1'b0, 1'b0);
    send_word(8'h66, 1'b0, 1'b1);
    chk("fp_ovf", 32'(overflow), 32'd0);
    chk("fp_head", 32'(out_word), 32'h55);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("fp_next", 32'(out_word), 32'h66);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("fp_empty", 32'(out_valid), 32'd0);

    // asynchronous reset mid-word with one buffered entry and overflow set
    send_word(8'hA5, 1'b0, 1'b0);
    send_word(8'h5A, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_ovf", 32'(overflow), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_word", 32'(out_word), 32'd0);
    chk("arst_y", 32'(out_y), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    model_clear();
    sin_valid = 1'b0;
    sin_start = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
    send_word(8'h6C, 1'b1, 1'b1);
    chk("post_rst_word", 32'(out_word), 32'h6C);
    chk("post_rst_y", 32'(out_y), 32'hA);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      cyc($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 15) == 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
